// File: rtl/matrix_load_sequencer_pkg.sv
// Shared types for the matrix-vector front-end loader: FSM states,
// default geometry and the grouped strobe bundle driven toward the processors.
package matrix_load_sequencer_pkg;

  localparam int MAX_N    = 8;
  localparam int NUM_PROC = 4;
  localparam int CNT_W    = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_MATRIX,
    S_LOAD_VECTOR,
    S_START,
    S_WAIT_DONE
  } LOAD_SEQ_STATE;

  typedef struct packed {
    logic       push_row;
    logic [1:0] row_fifo_sel;
    logic       push_vec;
    logic       start;
  } LOAD_SEQ_SIGNALS;

endpackage

// File: rtl/matrix_load_sequencer_if.sv
// Stream input, FIFO write side and controller handshake of the loader.
// master = sequencer, slave = surrounding stream source / FIFOs / controller.
interface matrix_load_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PROC   = 4
);
  logic                  abort;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [NUM_PROC-1:0]   row_fifo_full;
  logic                  vec_fifo_full;
  logic                  push_row;
  logic [1:0]            row_fifo_sel;
  logic [DATA_WIDTH-1:0] row_data;
  logic                  push_vec;
  logic [DATA_WIDTH-1:0] vec_data;
  logic [3:0]            n_cfg;
  logic                  start;
  logic                  op_done;
  logic                  busy;
  logic                  err_bad_n;

  modport master (
    input  abort, rx_data, rx_valid, row_fifo_full, vec_fifo_full, op_done,
    output rx_ready, push_row, row_fifo_sel, row_data, push_vec, vec_data,
           n_cfg, start, busy, err_bad_n
  );

  modport slave (
    output abort, rx_data, rx_valid, row_fifo_full, vec_fifo_full, op_done,
    input  rx_ready, push_row, row_fifo_sel, row_data, push_vec, vec_data,
           n_cfg, start, busy, err_bad_n
  );
endinterface

// File: rtl/matrix_load_sequencer_load_index_counter.sv
// Row-major 2-D element counter bounded by N; wrap_col marks the last column,
// last marks the final (N-1, N-1) element. clr has priority over inc.
module load_index_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W:0]   bound_i,
  output logic [CNT_W-1:0] row_o,
  output logic             wrap_col_o,
  output logic             last_o
);
  logic [CNT_W-1:0] row_q, row_d, col_q, col_d, lim;

  assign lim        = CNT_W'(bound_i - 1'b1);
  assign wrap_col_o = (col_q == lim);
  assign last_o     = wrap_col_o && (row_q == lim);
  assign row_o      = row_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (inc_i) begin
      if (wrap_col_o) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end
endmodule

// File: rtl/matrix_load_sequencer.sv
// Steers an N, matrix, vector byte stream into per-row processor FIFOs and the
// vector FIFO with zero-latency pushes, then pulses start and waits for op_done.
module matrix_load_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_N      = matrix_load_sequencer_pkg::MAX_N,
  parameter int NUM_PROC   = matrix_load_sequencer_pkg::NUM_PROC
) (
  input logic                    clk,
  input logic                    reset,
  matrix_load_sequencer_if.master bus
);
  import matrix_load_sequencer_pkg::*;

  LOAD_SEQ_STATE   state_q, state_d;
  LOAD_SEQ_SIGNALS ctl;
  logic [3:0]      n_cfg_q, n_cfg_d;
  logic            err_q, err_d;
  logic            rdy, accept, legal_n;
  logic            cnt_clr, cnt_inc, wrap_col, last_elem;
  logic [2:0]      row_cnt;
  logic [1:0]      proc_sel;

  load_index_counter #(.CNT_W(3)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (cnt_clr),
    .inc_i      (cnt_inc),
    .bound_i    (n_cfg_q),
    .row_o      (row_cnt),
    .wrap_col_o (wrap_col),
    .last_o     (last_elem)
  );

  assign proc_sel = 2'(32'(row_cnt) % NUM_PROC);
  assign legal_n  = (bus.rx_data != '0) && (bus.rx_data <= DATA_WIDTH'(MAX_N));
  assign accept   = bus.rx_valid && rdy;

  // Abort and reset both mask ready so no push can slip through that cycle.
  always_comb begin
    rdy = 1'b0;
    case (state_q)
      S_IDLE:        rdy = 1'b1;
      S_LOAD_MATRIX: rdy = ~bus.row_fifo_full[proc_sel];
      S_LOAD_VECTOR: rdy = ~bus.vec_fifo_full;
      default:       rdy = 1'b0;
    endcase
    if (reset || bus.abort) rdy = 1'b0;
  end

  always_comb begin
    state_d          = state_q;
    n_cfg_d          = n_cfg_q;
    err_d            = 1'b0;
    cnt_clr          = 1'b0;
    cnt_inc          = 1'b0;
    ctl              = '0;
    ctl.row_fifo_sel = proc_sel;
    case (state_q)
      S_IDLE: begin
        cnt_clr = 1'b1;
        if (accept) begin
          if (legal_n) begin
            n_cfg_d = bus.rx_data[3:0];
            state_d = S_LOAD_MATRIX;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD_MATRIX: begin
        if (accept) begin
          ctl.push_row = 1'b1;
          cnt_inc      = 1'b1;
          if (last_elem) begin
            cnt_clr = 1'b1;
            state_d = S_LOAD_VECTOR;
          end
        end
      end
      S_LOAD_VECTOR: begin
        if (accept) begin
          ctl.push_vec = 1'b1;
          cnt_inc      = 1'b1;
          if (wrap_col) state_d = S_START;
        end
      end
      S_START: begin
        ctl.start = 1'b1;
        state_d   = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (bus.op_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.abort) begin
      state_d = S_IDLE;
      cnt_clr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_cfg_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_cfg_q <= n_cfg_d;
      err_q   <= err_d;
    end
  end

  assign bus.rx_ready     = rdy;
  assign bus.push_row     = ctl.push_row;
  assign bus.row_fifo_sel = ctl.row_fifo_sel;
  assign bus.row_data     = bus.rx_data;
  assign bus.push_vec     = ctl.push_vec;
  assign bus.vec_data     = bus.rx_data;
  assign bus.start        = ctl.start;
  assign bus.n_cfg        = n_cfg_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.err_bad_n    = err_q;
endmodule

// File: tb/tb_matrix_load_sequencer.sv
// Directed bench for matrix_load_sequencer: per-cycle vector table plus
// hand-written multi-cycle sequences (N=1, N=8, backpressure, abort, reset).
module tb_matrix_load_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  matrix_load_sequencer_if #(.DATA_WIDTH(8), .NUM_PROC(4)) bus ();

  matrix_load_sequencer #(.DATA_WIDTH(8), .MAX_N(8), .NUM_PROC(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Push monitor
  logic [9:0] row_log[$];
  logic [7:0] vec_log[$];
  int         start_cnt = 0;
  always @(negedge clk) begin
    if (bus.push_row) row_log.push_back({bus.row_fifo_sel, bus.row_data});
    if (bus.push_vec) vec_log.push_back(bus.vec_data);
    if (bus.start) start_cnt++;
  end

  task automatic clear_logs();
    row_log.delete();
    vec_log.delete();
    start_cnt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    int t;
    t = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = d;
    @(negedge clk);
    while (!bus.rx_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.rx_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: byte %0h never accepted, rx_ready=%b required 1", d, bus.rx_ready);
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  // Called one cycle after the START cycle has begun: walks WAIT_DONE -> IDLE.
  task automatic finish_op(input string name);
    bus.op_done = 1'b1;
    @(negedge clk);
    check({name, "_busy_wait"}, 32'(bus.busy), 32'd1);
    check({name, "_rdy_wait"}, 32'(bus.rx_ready), 32'd0);
    tick();
    bus.op_done = 1'b0;
    @(negedge clk);
    check({name, "_busy_idle"}, 32'(bus.busy), 32'd0);
    check({name, "_rdy_idle"}, 32'(bus.rx_ready), 32'd1);
    tick();
  endtask

  typedef struct {
    logic       rst, ab, vld;
    logic [7:0] dat;
    logic [3:0] rfull;
    logic       vfull, done;
    logic       e_rdy, e_prow;
    logic [1:0] e_sel;
    logic       e_pvec;
    logic [7:0] e_dat;
    logic       e_start, e_busy, e_err;
    logic [3:0] e_n;
  } vec_t;

  function automatic vec_t mk(int rst, int ab, int vld, int dat, int rfull, int vfull, int done,
                              int rdy, int prow, int sel, int pvec, int edat,
                              int st, int bsy, int err, int n);
    vec_t v;
    v.rst = 1'(rst);   v.ab = 1'(ab);        v.vld = 1'(vld);   v.dat = 8'(dat);
    v.rfull = 4'(rfull); v.vfull = 1'(vfull); v.done = 1'(done);
    v.e_rdy = 1'(rdy); v.e_prow = 1'(prow);  v.e_sel = 2'(sel); v.e_pvec = 1'(pvec);
    v.e_dat = 8'(edat); v.e_start = 1'(st);  v.e_busy = 1'(bsy); v.e_err = 1'(err);
    v.e_n = 4'(n);
    return v;
  endfunction

  localparam int NV = 21;
  vec_t tbl[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_bad, hold_bad, map_bad, row5;
    //          rst ab vld dat rf vf dn | rdy prow sel pvec dat st bsy err n
    tbl[0]  = mk(1, 0, 1,  3, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1,  0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1,  9, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[3]  = mk(0, 0, 0,  0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[4]  = mk(0, 0, 1,  2, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 1,  1, 0, 0, 0,   1, 1, 0, 0, 1, 0, 1, 0, 2);
    tbl[6]  = mk(0, 0, 1,  2, 0, 0, 0,   1, 1, 0, 0, 2, 0, 1, 0, 2);
    tbl[7]  = mk(0, 0, 1,  3, 1, 0, 0,   1, 1, 1, 0, 3, 0, 1, 0, 2);
    tbl[8]  = mk(0, 0, 1,  4, 0, 0, 0,   1, 1, 1, 0, 4, 0, 1, 0, 2);
    tbl[9]  = mk(0, 0, 1,  5, 0, 0, 1,   1, 0, 0, 1, 5, 0, 1, 0, 2);
    tbl[10] = mk(0, 0, 0,  0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 1, 0, 2);
    tbl[11] = mk(0, 0, 1,  6, 0, 0, 0,   1, 0, 0, 1, 6, 0, 1, 0, 2);
    tbl[12] = mk(0, 0, 1,  7, 0, 0, 0,   0, 0, 0, 0, 0, 1, 1, 0, 2);
    tbl[13] = mk(0, 0, 1,  7, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0, 2);
    tbl[14] = mk(0, 0, 1,  7, 0, 0, 1,   0, 0, 0, 0, 0, 0, 1, 0, 2);
    tbl[15] = mk(0, 0, 0,  0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 2);
    tbl[16] = mk(0, 0, 1,  9, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 2);
    tbl[17] = mk(0, 0, 1,  3, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 2);
    tbl[18] = mk(0, 0, 0,  0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1, 0, 3);
    tbl[19] = mk(0, 1, 1,  8, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0, 3);
    tbl[20] = mk(0, 0, 0,  0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 3);

    reset = 1'b1;
    bus.abort = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = '0;
    bus.row_fifo_full = '0;
    bus.vec_fifo_full = 1'b0;
    bus.op_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      reset             = tbl[i].rst;
      bus.abort         = tbl[i].ab;
      bus.rx_valid      = tbl[i].vld;
      bus.rx_data       = tbl[i].dat;
      bus.row_fifo_full = tbl[i].rfull;
      bus.vec_fifo_full = tbl[i].vfull;
      bus.op_done       = tbl[i].done;
      @(negedge clk);
      check($sformatf("v%0d_rx_ready", i), 32'(bus.rx_ready), 32'(tbl[i].e_rdy));
      check($sformatf("v%0d_push_row", i), 32'(bus.push_row), 32'(tbl[i].e_prow));
      check($sformatf("v%0d_push_vec", i), 32'(bus.push_vec), 32'(tbl[i].e_pvec));
      check($sformatf("v%0d_start", i), 32'(bus.start), 32'(tbl[i].e_start));
      check($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(tbl[i].e_busy));
      check($sformatf("v%0d_err_bad_n", i), 32'(bus.err_bad_n), 32'(tbl[i].e_err));
      check($sformatf("v%0d_n_cfg", i), 32'(bus.n_cfg), 32'(tbl[i].e_n));
      if (tbl[i].e_prow) begin
        check($sformatf("v%0d_row_sel", i), 32'(bus.row_fifo_sel), 32'(tbl[i].e_sel));
        check($sformatf("v%0d_row_data", i), 32'(bus.row_data), 32'(tbl[i].e_dat));
      end
      if (tbl[i].e_pvec)
        check($sformatf("v%0d_vec_data", i), 32'(bus.vec_data), 32'(tbl[i].e_dat));
      tick();
    end
    reset = 1'b0;
    bus.abort = 1'b0;
    bus.rx_valid = 1'b0;
    bus.op_done = 1'b0;
    bus.row_fifo_full = '0;
    bus.vec_fifo_full = 1'b0;

    // N=1: one element to processor 0, one vector element, then start
    clear_logs();
    send_byte(8'd1);
    send_byte(8'h21);
    send_byte(8'h22);
    @(negedge clk);
    check("n1_start", 32'(bus.start), 32'd1);
    tick();
    check("n1_row_cnt", 32'(row_log.size()), 32'd1);
    check("n1_row0", (row_log.size() > 0) ? 32'(row_log[0]) : 32'hdead, 32'h021);
    check("n1_vec0", (vec_log.size() > 0) ? 32'(vec_log[0]) : 32'hdead, 32'h22);
    finish_op("n1");

    // N=8: full stream, row-to-processor mapping and strobe counts
    clear_logs();
    send_byte(8'd8);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        send_byte(8'(r * 8 + c + 1));
    for (int c = 0; c < 8; c++) send_byte(8'(101 + c));
    hold_bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (!bus.busy) hold_bad++;
      tick();
    end
    check("n8_busy_hold", 32'(hold_bad), 32'd0);
    finish_op("n8");
    check("n8_push_row_cnt", 32'(row_log.size()), 32'd64);
    check("n8_push_vec_cnt", 32'(vec_log.size()), 32'd8);
    check("n8_start_cnt", 32'(start_cnt), 32'd1);
    map_bad = 0;
    row5 = 0;
    for (int k = 0; k < row_log.size(); k++) begin
      if (row_log[k][7:0] != 8'(k + 1) || row_log[k][9:8] != 2'((k / 8) % 4)) map_bad++;
      if (row_log[k][7:0] >= 8'd41 && row_log[k][7:0] <= 8'd48 && row_log[k][9:8] == 2'd1) row5++;
    end
    for (int k = 0; k < vec_log.size(); k++)
      if (vec_log[k] != 8'(101 + k)) map_bad++;
    check("n8_order_map", 32'(map_bad), 32'd0);
    check("n8_row5_proc1", 32'(row5), 32'd8);

    // N=4 with processor 2 FIFO full for 3 cycles at the start of row 2
    clear_logs();
    send_byte(8'd4);
    for (int k = 1; k <= 8; k++) send_byte(8'(k));
    bus.row_fifo_full = 4'b0100;
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'd9;
    stall_bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.rx_ready || bus.push_row || bus.row_fifo_sel != 2'd2) stall_bad++;
      tick();
    end
    check("bp_stall", 32'(stall_bad), 32'd0);
    check("bp_no_push", 32'(row_log.size()), 32'd8);
    bus.row_fifo_full = '0;
    for (int k = 9; k <= 16; k++) send_byte(8'(k));
    for (int k = 17; k <= 20; k++) send_byte(8'(k));
    @(negedge clk);
    check("bp_start", 32'(bus.start), 32'd1);
    tick();
    finish_op("bp");
    check("bp_row_cnt", 32'(row_log.size()), 32'd16);
    map_bad = 0;
    for (int k = 0; k < row_log.size(); k++)
      if (row_log[k] != {2'(k / 4), 8'(k + 1)}) map_bad++;
    for (int k = 0; k < vec_log.size(); k++)
      if (vec_log[k] != 8'(17 + k)) map_bad++;
    check("bp_order", 32'(map_bad), 32'd0);
    check("bp_vec_cnt", 32'(vec_log.size()), 32'd4);

    // Abort on the 5th matrix element of N=3
    clear_logs();
    send_byte(8'd3);
    for (int k = 1; k <= 4; k++) send_byte(8'(k));
    bus.abort = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'd5;
    @(negedge clk);
    check("abort_rdy", 32'(bus.rx_ready), 32'd0);
    check("abort_push", 32'(bus.push_row), 32'd0);
    tick();
    bus.abort = 1'b0;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    check("abort_idle", 32'(bus.busy), 32'd0);
    check("abort_n_kept", 32'(bus.n_cfg), 32'd3);
    check("abort_pushes", 32'(row_log.size()), 32'd4);
    tick();
    send_byte(8'd2);
    @(negedge clk);
    check("abort_next_n", 32'(bus.n_cfg), 32'd2);
    check("abort_next_busy", 32'(bus.busy), 32'd1);
    tick();

    // Reset mid-load clears n_cfg
    for (int k = 1; k <= 3; k++) send_byte(8'(k));
    reset = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'd4;
    @(negedge clk);
    check("rst_rdy", 32'(bus.rx_ready), 32'd0);
    check("rst_push", 32'(bus.push_row), 32'd0);
    tick();
    reset = 1'b0;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    check("rst_n_cfg", 32'(bus.n_cfg), 32'd0);
    check("rst_idle", 32'(bus.busy), 32'd0);
    check("rst_rdy_after", 32'(bus.rx_ready), 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
